sample_logger: RTL

- Parametrised successor to the single-channel sensor-data-plus-timestamp path.
- Accepts fixed-width sample words from NUM_CH sensor channels and arbitrates among them round-robin.
- Tags each accepted sample with channel ID and current TIMESTAMP, buffers records in a DEPTH-entry FIFO.
- Streams records out byte-serially, MSB first, to the downlink/test-harness byte interface.

---
 rtl/sample_logger_pkg.sv | 29 ++
 rtl/sample_logger_if.sv | 10 +
 rtl/sample_logger_fifo.sv | 57 +++++
 rtl/sample_logger.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sample_logger_pkg.sv
// Shared constants, record layout helpers and serializer state type for the
// multi-channel sample logger.
package logger_pkg;

    localparam int CH_ID_W  = 8;
    localparam int DATA_LSB = 0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    function automatic int rec_width(input int ts_w, input int data_w);
        return CH_ID_W + ts_w + data_w;
    endfunction

    function automatic int nbytes(input int rec_w);
        return rec_w / 8;
    endfunction

    function automatic int ts_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int id_lsb(input int ts_w, input int data_w);
        return DATA_LSB + data_w + ts_w;
    endfunction

endpackage

// File: rtl/sample_logger_if.sv
// Byte-serial record stream from the logger to the downlink / test harness.
interface sample_logger_if;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT_BYTE;
    logic       OUT_SOF;

    modport master (output OUT_VALID, output OUT_BYTE, output OUT_SOF, input OUT_READY);
    modport slave  (input OUT_VALID, input OUT_BYTE, input OUT_SOF, output OUT_READY);
endinterface

// File: rtl/sample_logger_fifo.sv
// Single-clock record FIFO with first-word-fall-through read data.
module logger_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/sample_logger.sv
// Round-robin multi-channel sample logger: tags samples with channel ID and
// timestamp, buffers them and streams each record out MSB byte first.
module sample_logger
    import logger_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 80,
    parameter int TS_W         = 24,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 1,
    parameter int OVF_W        = 16
) (
    input  logic                   CLK_1MHZ,
    input  logic                   RESET,
    input  logic [TS_W-1:0]        TIMESTAMP,
    input  logic [NUM_CH-1:0]      CH_VALID,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    output logic [NUM_CH-1:0]      CH_READY,
    sample_logger_if.master        out_if,
    output logic [$clog2(DEPTH):0] FIFO_COUNT,
    output logic [OVF_W-1:0]       OVERFLOW_CNT
);

    localparam int REC_W  = rec_width(TS_W, DATA_W);
    localparam int NBYTES = nbytes(REC_W);
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TS_LSB = ts_lsb(DATA_W);
    localparam int ID_LSB = id_lsb(TS_W, DATA_W);

    localparam logic [PTR_W:0]   NUM_CH_C = (PTR_W+1)'(NUM_CH);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [PTR_W-1:0]    r_ptr;
    logic [2*NUM_CH-1:0] w_req_dbl;
    logic [NUM_CH-1:0]   w_req_rot;
    logic [PTR_W-1:0]    w_off;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_grant;
    logic                w_grant_vld;
    logic                w_xfer;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [DATA_W-1:0]   w_data;
    logic [REC_W-1:0]    w_rec;
    logic [REC_W-1:0]    w_dout;
    logic [OVF_W-1:0]    r_ovf;

    ser_state_t          r_state;
    ser_state_t          w_state_nxt;
    logic [REC_W-1:0]    r_shift;
    logic [REC_W-1:0]    w_shift_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                r_out_valid;
    logic                r_out_sof;
    logic [7:0]          r_out_byte;

    // Grant the first requester at or after the pointer: rotate, pick lowest, rotate back.
    always_comb begin
        w_req_dbl   = {CH_VALID, CH_VALID} >> r_ptr;
        w_req_rot   = w_req_dbl[NUM_CH-1:0];
        w_off       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_off = w_req_rot[k] ? PTR_W'(k) : w_off;
        end
        w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
        w_grant     = (w_sum >= NUM_CH_C) ? PTR_W'(w_sum - NUM_CH_C) : PTR_W'(w_sum);
        w_grant_vld = |CH_VALID;
    end

    assign w_xfer   = w_grant_vld && !RESET && !(w_full && (DROP_ON_FULL == 0));
    assign w_push   = w_xfer && !w_full;
    assign w_drop   = w_xfer && w_full;
    assign CH_READY = w_xfer ? (NUM_CH'(1'b1) << w_grant) : '0;

    // Assemble {channel ID, timestamp, data} for the granted channel.
    always_comb begin
        w_data = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_data = (w_grant == PTR_W'(ch)) ? CH_DATA[ch*DATA_W +: DATA_W] : w_data;
        end
        w_rec                         = '0;
        w_rec[ID_LSB +: CH_ID_W]      = CH_ID_W'(w_grant);
        w_rec[TS_LSB +: TS_W]         = TIMESTAMP;
        w_rec[DATA_LSB +: DATA_W]     = w_data;
    end

    // Arbiter pointer moves past the winner only when a transfer actually happens.
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            r_ptr <= '0;
            r_ovf <= '0;
        end else begin
            if (w_xfer) r_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
            if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
        end
    end

    logger_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK_1MHZ),
        .rst   (RESET),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_rec),
        .dout  (w_dout),
        .count (FIFO_COUNT),
        .full  (w_full),
        .empty (w_empty)
    );

    // Serializer next state; the shift register rotates so the current byte is always on top.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (out_if.OUT_READY && (r_idx == LAST_IDX)) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_dout;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (out_if.OUT_READY) begin
                    w_shift_nxt = {r_shift[REC_W-9:0], r_shift[REC_W-1 -: 8]};
                    w_idx_nxt   = r_idx + 1'b1;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Serializer state and registered byte-stream outputs.
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_byte  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= (w_state_nxt == S_SEND);
            r_out_sof   <= (w_state_nxt == S_SEND) && (w_idx_nxt == '0);
            r_out_byte  <= w_shift_nxt[REC_W-1 -: 8];
        end
    end

    assign out_if.OUT_VALID = r_out_valid;
    assign out_if.OUT_SOF   = r_out_sof;
    assign out_if.OUT_BYTE  = r_out_byte;
    assign OVERFLOW_CNT     = r_ovf;

endmodule
